sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 9, SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  requester has a pending access.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse, rsp_rdata valid.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, held until the next read response.
REQ-012 SHALL have port busy  output  1  clear sweep or access in progress.
REQ-013 SHALL have ports sram_ce, sram_wre, sram_oce  output  1  each  SRAM enables.
REQ-014 SHALL have ports sram_ad  output  ADDR_W and sram_din  output  DATA_W  SRAM address and write data.
REQ-015 SHALL have port sram_dout  input  DATA_W  SRAM read data (bypass read mode, valid after the same edge that samples the address).

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCESS, CAPTURE.
REQ-017 SHALL assert req_ready only in IDLE; a handshake occurs on an edge where req_valid && req_ready.
REQ-018 SHALL register req_we/req_addr/req_wdata into sram_wre/sram_ad/sram_din at handshake edge k and enter ACCESS.
REQ-019 SHALL drive sram_ce=1 only in ACCESS and CLEAR; sram_oce SHALL be constant 1.
REQ-020 SHALL leave ACCESS at edge k+1: to IDLE for writes, to CAPTURE for reads.
REQ-021 SHALL in CAPTURE load sram_dout into rsp_rdata at edge k+2, pulse rsp_valid for the cycle after k+2, and return to IDLE.
REQ-022 SHALL give read latency of exactly 2 cycles (handshake to rsp_valid) and throughput of one write per 2 cycles or one read per 3 cycles.
REQ-023 SHALL never issue rsp_valid for writes.
REQ-024 SHALL hold sram_ad/sram_din/sram_wre stable outside ACCESS/CLEAR (sram_wre=0 in IDLE, CAPTURE).
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL ignore req_* inputs while req_ready=0; no request is queued.

Reset
REQ-027 SHALL on reset set state to CLEAR (macro defined) or IDLE (macro undefined), sram_ce=0, sram_wre=0, sram_ad=0, sram_din=0, rsp_valid=0, rsp_rdata=0.
REQ-028 SHALL, on reset asserted mid-ACCESS/CAPTURE, drop the access with no rsp_valid; on reset mid-CLEAR, restart the sweep from address 0.

Configuration
REQ-029 SHALL compile the clear sweep only when macro SRAM_PORT_CTRL_CLEAR_EN is defined.
REQ-030 SHALL, with the macro, write 0 to addresses 0..2^ADDR_W-1, one per cycle, in CLEAR (sram_ce=1, sram_wre=1), then enter IDLE after the last address (2^ADDR_W cycles, address counter wraps to 0).
REQ-031 SHALL, without the macro, omit CLEAR and its counter; memory contents after reset are the SRAM initial values.

Structure
REQ-032 SHALL take ADDR_W/DATA_W defaults, DEPTH and the state enum from shared package nano_mem_pkg.
REQ-033 SHALL be a single module; no sub-module (the clear counter is folded into the FSM).

Verification
REQ-034 SHALL verify with macro: reset release -> busy=1 for 128 cycles, sram_wre=1 with sram_ad 0..127, then req_ready=1; readback of addr 0x45 -> 0x000.
REQ-035 SHALL verify write 0x1A5 to addr 0x10 then read addr 0x10 -> rsp_valid exactly 2 cycles after read handshake, rsp_rdata=0x1A5.
REQ-036 SHALL verify back-to-back req_valid held high: write 0x7F, write 0x7E, read 0x7F -> req_ready low for one cycle after each write, rsp_rdata matches.
REQ-037 SHALL verify reset asserted during CAPTURE -> no rsp_valid, outputs at reset values, state per macro.
REQ-038 SHALL verify without macro: reset release -> req_ready=1 on the first cycle, busy=0.
REQ-039 SHALL verify rsp_rdata holds its value across subsequent writes until the next read response.

Source files
------------

// File: rtl/nano_mem_pkg.sv
// Shared definitions for the nano memory blocks: default geometry and the
// SRAM port controller state encoding.
package nano_mem_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 9;
    localparam int DEPTH      = 1 << ADDR_W_DEF;

    // Controller states with fixed encodings so waveforms stay readable
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM access controller. A request is taken only in IDLE. The
// address, data and write enable are registered straight onto the SRAM pins.
// Reads return through a one-cycle rsp_valid pulse, two cycles after the
// handshake.
// Optional feature: define SRAM_PORT_CTRL_CLEAR_EN to zero the whole memory
// after every reset before the first request is accepted.
module sram_port_ctrl
    import nano_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sram_ce,
    output logic              sram_wre,
    output logic              sram_oce,
    output logic [ADDR_W-1:0] sram_ad,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

`ifdef SRAM_PORT_CTRL_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e state;

    // Handshake and status flags decode directly from the state
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign sram_oce  = 1'b1;

    // Main FSM; sram_ad doubles as the sweep counter while clearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RESET_STATE;
            sram_ce   <= 1'b0;
            sram_wre  <= 1'b0;
            sram_ad   <= '0;
            sram_din  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        sram_ce  <= 1'b1;
                        sram_wre <= req_we;
                        sram_ad  <= req_addr;
                        sram_din <= req_wdata;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // The SRAM samples the pins on this edge; reads finish next cycle
                    sram_ce  <= 1'b0;
                    sram_wre <= 1'b0;
                    state    <= sram_wre ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_rdata <= sram_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
`ifdef SRAM_PORT_CTRL_CLEAR_EN
                ST_CLEAR: begin
                    if (!sram_wre) begin
                        // First cycle out of reset: arm the write enables at address 0
                        sram_ce  <= 1'b1;
                        sram_wre <= 1'b1;
                        sram_ad  <= '0;
                        sram_din <= '0;
                    end else begin
                        // Address wraps back to 0 after the last word is written
                        sram_ad <= sram_ad + 1'b1;
                        if (sram_ad == {ADDR_W{1'b1}}) begin
                            sram_ce  <= 1'b0;
                            sram_wre <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    sram_ce  <= 1'b0;
                    sram_wre <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural bypass-mode SRAM.
module tb_sram_port_ctrl;
    import nano_mem_pkg::*;

    localparam int AW = 7;
    localparam int DW = 9;

`ifdef SRAM_PORT_CTRL_CLEAR_EN
    localparam logic [DW-1:0] EXP_45  = 9'h000;
    localparam logic [DW-1:0] EXP_30  = 9'h000;
    localparam logic [DW-1:0] EXP_R10 = 9'h000;
    localparam logic          EXP_RST_BUSY = 1'b1;
`else
    localparam logic [DW-1:0] EXP_45  = 9'h145;
    localparam logic [DW-1:0] EXP_30  = 9'h130;
    localparam logic [DW-1:0] EXP_R10 = 9'h1A5;
    localparam logic          EXP_RST_BUSY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy, sram_ce, sram_wre, sram_oce;
    logic [AW-1:0] sram_ad;
    logic [DW-1:0] sram_din, sram_dout;
    logic          mem_init;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sram_ce(sram_ce), .sram_wre(sram_wre), .sram_oce(sram_oce),
        .sram_ad(sram_ad), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Bypass-mode SRAM: dout reflects the word addressed at the sampling edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(9'h100 + i);
        end else if (sram_ce) begin
            if (sram_wre) begin
                mem[sram_ad] <= sram_din;
                sram_dout    <= sram_din;
            end else begin
                sram_dout <= mem[sram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the controller in IDLE
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
        chk({tag, "_pins"}, {14'd0, sram_ce, sram_wre, 7'(sram_ad), 9'(sram_din)},
            {14'd0, 1'b1, 1'b1, 7'(a), 9'(d)});
        @(posedge clk); #1;
        chk({tag, "_back"}, {29'd0, req_ready, sram_wre, rsp_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        int   lat;
        logic seen;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

`ifdef SRAM_PORT_CTRL_CLEAR_EN
    // Entered at #1 after the first edge following reset release
    task automatic sweep_check(input string tag);
        int n = 0, bad = 0, rsp = 0;
        while (busy && n < 300) begin
            if (!(sram_ce && sram_wre && sram_ad == AW'(n) && sram_din == '0)) bad++;
            if (rsp_valid) rsp++;
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_len"}, 32'(n), 32'd128);
        chk({tag, "_seq"}, 32'(bad), 32'd0);
        chk({tag, "_rsp"}, 32'(rsp), 32'd0);
        chk({tag, "_end"}, {30'd0, req_ready, sram_wre}, {30'd0, 1'b1, 1'b0});
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk("rst_pins", {13'd0, sram_ce, sram_wre, sram_oce, 7'(sram_ad), 9'(sram_din)},
            {13'd0, 1'b0, 1'b0, 1'b1, 7'd0, 9'd0});
        chk("rst_rsp", {22'd0, rsp_valid, 9'(rsp_rdata)}, 32'd0);
        chk("rst_busy", 32'(busy), 32'(EXP_RST_BUSY));
        reset = 1'b0;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
        @(posedge clk); #1;
        sweep_check("clr");
`else
        chk("boot_rdy", {30'd0, req_ready, busy}, {30'd0, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("boot_rdy1", {30'd0, req_ready, busy}, {30'd0, 1'b1, 1'b0});
`endif
        do_read(7'h45, EXP_45, "rd45");

        do_write(7'h10, 9'h1A5, "wr10");
        do_read(7'h10, 9'h1A5, "rd10");

        // Back-to-back with req_valid held high
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h7F; req_wdata = 9'h0AA;
        @(posedge clk); #1;
        chk("b2b_w1_rdy", {30'd0, req_ready, rsp_valid}, 32'd0);
        req_addr = 7'h7E; req_wdata = 9'h155;
        @(posedge clk); #1;
        chk("b2b_w1_back", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_w2_rdy", {30'd0, req_ready, rsp_valid}, 32'd0);
        chk("b2b_w2_ad", 32'(sram_ad), 32'h7E);
        req_we = 1'b0; req_addr = 7'h7F;
        @(posedge clk); #1;
        chk("b2b_w2_back", 32'(req_ready), 32'd1);
        chk("hold_rdata", 32'(rsp_rdata), 32'h1A5);
        do_read(7'h7F, 9'h0AA, "b2b_rd");
        do_read(7'h7E, 9'h155, "rd7e");

        // A request presented while not ready must be dropped, not queued
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h20; req_wdata = 9'h033;
        @(posedge clk); #1;
        req_addr = 7'h30; req_wdata = 9'h111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("noq_rdy", {30'd0, req_ready, sram_ce}, {30'd0, 1'b1, 1'b0});
        do_read(7'h30, EXP_30, "noq_rd30");
        do_read(7'h20, 9'h033, "rd20");

        // Reset while the read is in CAPTURE
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("cap_busy", {30'd0, busy, rsp_valid}, {30'd0, 1'b1, 1'b0});
        reset = 1'b1;
        #1;
        chk("cap_rst_pins", {14'd0, sram_ce, sram_wre, 7'(sram_ad), 9'(sram_din)}, 32'd0);
        chk("cap_rst_rsp", {22'd0, rsp_valid, 9'(rsp_rdata)}, 32'd0);
        chk("cap_rst_state", {30'd0, busy, req_ready}, {30'd0, EXP_RST_BUSY, ~EXP_RST_BUSY});
        @(posedge clk); #1;
        chk("cap_rst_hold", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
`ifdef SRAM_PORT_CTRL_CLEAR_EN
        @(posedge clk); #1;
        sweep_check("clr2");
`else
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {29'd0, req_ready, busy, rsp_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        end
`endif
        do_read(7'h10, EXP_R10, "post_rst_rd10");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
